instability_sweep_ctrl: RTL and testbench

Sequencer for the optical-resonance instability search. On request it steps the reference-current code `i_ref` downward from a start value, waits a settling time at each step and triggers one Q measurement. It stops at the first step where the measured Q jumps by more than a threshold over the previous step. The last stable code is handed to the Q control loop as its upper bound; the sweep reports failure if the range is exhausted or the measurement unit stops responding.

---
 rtl/instability_sweep_ctrl.sv | 175 +++++++++++++++++
 tb/tb_instability_sweep_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instability_sweep_ctrl.sv
// Instability search sequencer: steps i_ref down from I_REF_START, measures Q at each
// step and stops at the first Q jump above DELTA_Q_INSTB, reporting the last stable code.
module instability_sweep_ctrl #(
  parameter int unsigned BUS_WIDTH     = 10,
  parameter int unsigned I_REF_START   = 2**BUS_WIDTH - 1,
  parameter int unsigned I_REF_STEP    = 50,
  parameter int unsigned I_REF_MIN     = 0,
  parameter int unsigned DELTA_Q_INSTB = 300,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MEAS_TIMEOUT  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 meas_done,
  input  logic [BUS_WIDTH-1:0] q_measured,
  output logic                 meas_start,
  output logic [BUS_WIDTH-1:0] i_ref,
  output logic                 busy,
  output logic                 setup_done,
  output logic                 setup_fail,
  output logic [1:0]           fail_code,
  output logic [BUS_WIDTH-1:0] i_ref_bound
);

  localparam int unsigned EW      = BUS_WIDTH + 1;
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > MEAS_TIMEOUT) ? SETTLE_CYCLES : MEAS_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [BUS_WIDTH-1:0] LP_START       = BUS_WIDTH'(I_REF_START);
  localparam logic [BUS_WIDTH-1:0] LP_STEP        = BUS_WIDTH'(I_REF_STEP);
  localparam logic [EW-1:0]        LP_LOW_LIMIT   = EW'(I_REF_MIN + I_REF_STEP);
  localparam logic [EW-1:0]        LP_DELTA       = EW'(DELTA_Q_INSTB);
  localparam logic [CNT_W-1:0]     LP_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     LP_TMO_LAST    = CNT_W'(MEAS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_EVAL,
    S_DONE,
    S_FAIL
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BUS_WIDTH-1:0] r_curr_q;
  logic [BUS_WIDTH-1:0] r_last_q;
  logic                 r_first;
  logic                 r_meas_start;
  logic [BUS_WIDTH-1:0] r_i_ref;
  logic                 r_busy;
  logic                 r_setup_done;
  logic                 r_setup_fail;
  logic [1:0]           r_fail_code;
  logic [BUS_WIDTH-1:0] r_i_ref_bound;

  logic [BUS_WIDTH-1:0] w_dq;
  logic                 w_jump;
  logic                 w_at_floor;
  logic [BUS_WIDTH-1:0] w_prev_code;

  // Difference only qualifies when Q rose, so the unsigned wrap of a drop is never used
  assign w_dq        = r_curr_q - r_last_q;
  assign w_jump      = !r_first && (r_curr_q > r_last_q) && ({1'b0, w_dq} > LP_DELTA);
  assign w_at_floor  = {1'b0, r_i_ref} < LP_LOW_LIMIT;
  assign w_prev_code = r_i_ref + LP_STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_curr_q      <= '0;
      r_last_q      <= '0;
      r_first       <= 1'b0;
      r_meas_start  <= 1'b0;
      r_i_ref       <= LP_START;
      r_busy        <= 1'b0;
      r_setup_done  <= 1'b0;
      r_setup_fail  <= 1'b0;
      r_fail_code   <= '0;
      r_i_ref_bound <= '0;
    end else begin
      r_meas_start <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            r_state       <= S_SETTLE;
            r_i_ref       <= LP_START;
            r_first       <= 1'b1;
            r_cnt         <= LP_SETTLE_LOAD;
            r_busy        <= 1'b1;
            r_setup_done  <= 1'b0;
            r_setup_fail  <= 1'b0;
            r_fail_code   <= '0;
            r_i_ref_bound <= '0;
          end
        end

        S_SETTLE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_i_ref <= LP_START;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state      <= S_MEASURE;
            r_meas_start <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_MEASURE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_i_ref <= LP_START;
            r_busy  <= 1'b0;
          end else if (meas_done) begin
            r_last_q <= r_curr_q;
            r_curr_q <= q_measured;
            r_state  <= S_EVAL;
          end else if (r_cnt == LP_TMO_LAST) begin
            r_state      <= S_FAIL;
            r_busy       <= 1'b0;
            r_setup_fail <= 1'b1;
            r_fail_code  <= 2'd2;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_EVAL: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_i_ref <= LP_START;
            r_busy  <= 1'b0;
          end else if (w_jump) begin
            r_state       <= S_DONE;
            r_busy        <= 1'b0;
            r_setup_done  <= 1'b1;
            r_i_ref_bound <= w_prev_code;
            r_i_ref       <= w_prev_code;
          end else if (w_at_floor) begin
            r_state      <= S_FAIL;
            r_busy       <= 1'b0;
            r_setup_fail <= 1'b1;
            r_fail_code  <= 2'd1;
          end else begin
            r_state <= S_SETTLE;
            r_i_ref <= r_i_ref - LP_STEP;
            r_first <= 1'b0;
            r_cnt   <= LP_SETTLE_LOAD;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_i_ref <= LP_START;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign meas_start  = r_meas_start;
  assign i_ref       = r_i_ref;
  assign busy        = r_busy;
  assign setup_done  = r_setup_done;
  assign setup_fail  = r_setup_fail;
  assign fail_code   = r_fail_code;
  assign i_ref_bound = r_i_ref_bound;

endmodule

// File: tb/tb_instability_sweep_ctrl.sv
// Self-checking bench for instability_sweep_ctrl: behavioural measurement unit plus a
// sweep-outcome model built from the code ladder and Q table.
module tb_instability_sweep_ctrl;

  localparam int BW     = 10;
  localparam int START  = 1023;
  localparam int STEP   = 50;
  localparam int MINC   = 0;
  localparam int DELTA  = 300;
  localparam int SETTLE = 16;
  localparam int TMO    = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          meas_done;
  logic [BW-1:0] q_measured;
  logic          meas_start;
  logic [BW-1:0] i_ref;
  logic          busy;
  logic          setup_done;
  logic          setup_fail;
  logic [1:0]    fail_code;
  logic [BW-1:0] i_ref_bound;

  always #5 clk = ~clk;

  instability_sweep_ctrl #(
    .BUS_WIDTH    (BW),
    .I_REF_START  (START),
    .I_REF_STEP   (STEP),
    .I_REF_MIN    (MINC),
    .DELTA_Q_INSTB(DELTA),
    .SETTLE_CYCLES(SETTLE),
    .MEAS_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .meas_done  (meas_done),
    .q_measured (q_measured),
    .meas_start (meas_start),
    .i_ref      (i_ref),
    .busy       (busy),
    .setup_done (setup_done),
    .setup_fail (setup_fail),
    .fail_code  (fail_code),
    .i_ref_bound(i_ref_bound)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Stimulus settings written by the main flow, read by the measurement unit
  logic [BW-1:0] q_tab [64];
  int            resp_lat   = 5;
  bit            resp_mute  = 1'b0;
  int            abort_step = -1;
  int            sweep_id   = 0;

  // Measurement unit: answers each meas_start after resp_lat cycles with the next table entry
  logic          auto_done  = 1'b0;
  logic          auto_abort = 1'b0;
  logic [BW-1:0] auto_q     = '0;
  logic [BW-1:0] code_log [$];
  int            seen_id = 0;
  int            r_idx   = 0;
  int            r_cnt   = 0;
  bit            r_pend  = 1'b0;

  assign meas_done  = auto_done;
  assign q_measured = auto_q;
  assign abort      = auto_abort;

  always @(negedge clk) begin
    auto_done  = 1'b0;
    auto_abort = 1'b0;
    if (rst) begin
      r_pend = 1'b0;
    end else begin
      if (seen_id != sweep_id) begin
        seen_id = sweep_id;
        r_idx   = 0;
        r_pend  = 1'b0;
        code_log.delete();
      end
      if (r_pend) begin
        r_cnt--;
        if (r_cnt == 0) begin
          r_pend    = 1'b0;
          auto_done = 1'b1;
          auto_q    = q_tab[r_idx];
          if (r_idx == abort_step) auto_abort = 1'b1;
          r_idx++;
        end
      end
      if (meas_start) begin
        code_log.push_back(i_ref);
        if (!resp_mute) begin
          r_pend = 1'b1;
          r_cnt  = resp_lat;
        end
      end
    end
  end

  task automatic set_tab4(input int a, input int b, input int c, input int d);
    for (int k = 0; k < 64; k++)
      q_tab[k] = BW'((k == 0) ? a : (k == 1) ? b : (k == 2) ? c : d);
  endtask

  // Outcome of a complete sweep over the current Q table
  int exp_done, exp_fail, exp_code, exp_bound, exp_iref, exp_n;

  task automatic model();
    int code = START;
    int prev = 0;
    exp_done = 0; exp_fail = 0; exp_code = 0; exp_bound = 0; exp_iref = START; exp_n = 0;
    for (int k = 0; k < 64; k++) begin
      int q = int'(q_tab[k]);
      if (k > 0 && q > prev && (q - prev) > DELTA) begin
        exp_done = 1; exp_bound = code + STEP; exp_iref = code + STEP; exp_n = k + 1;
        return;
      end
      if (code < MINC + STEP) begin
        exp_fail = 1; exp_code = 1; exp_iref = code; exp_n = k + 1;
        return;
      end
      code = code - STEP;
      prev = q;
    end
  endtask

  int got_bound, got_iref, got_n;

  task automatic run_sweep(input int lat, input int extra_start);
    int cyc;
    int first_ms;
    int limit;
    resp_lat = lat;
    resp_mute = 1'b0;
    model();
    sweep_id++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_done_clr", 32'(setup_done), 0);
    check("start_fail_clr", 32'(setup_fail), 0);
    check("start_code_clr", 32'(fail_code), 0);
    check("start_bound_clr", 32'(i_ref_bound), 0);
    check("start_iref", 32'(i_ref), START);
    cyc = 0;
    first_ms = -1;
    limit = 70 * (SETTLE + lat + 2) + 10;
    while (busy && cyc < limit) begin
      if (cyc == extra_start) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (meas_start && first_ms < 0) first_ms = cyc;
    end
    got_bound = int'(i_ref_bound);
    got_iref  = int'(i_ref);
    got_n     = code_log.size();
    check("sweep_ends", 32'(busy), 0);
    check("first_meas_start", first_ms, SETTLE);
    check("duration", cyc, exp_n * (SETTLE + lat + 2));
    check("done", 32'(setup_done), exp_done);
    check("fail", 32'(setup_fail), exp_fail);
    check("fail_code", 32'(fail_code), exp_code);
    check("bound", got_bound, exp_bound);
    check("iref_final", got_iref, exp_iref);
    check("n_meas", got_n, exp_n);
    for (int k = 0; k < got_n; k++)
      check("step_code", 32'(code_log[k]), START - k * STEP);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    start = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_iref", 32'(i_ref), START);
    check("rst_bound", 32'(i_ref_bound), 0);
    check("rst_done", 32'(setup_done), 0);
    check("rst_fail", 32'(setup_fail), 0);
    check("rst_code", 32'(fail_code), 0);
    check("rst_meas_start", 32'(meas_start), 0);
    @(negedge clk);
    rst = 1'b0;

    // Detection with explicit expectations
    set_tab4(100, 110, 120, 500);
    run_sweep(5, 3);
    check("det_bound", got_bound, 923);
    check("det_iref", got_iref, 923);
    check("det_pulses", got_n, 4);

    // Exhaustion (also restarts from DONE)
    set_tab4(200, 200, 200, 200);
    run_sweep(3, 0);
    check("exh_pulses", got_n, 21);
    check("exh_iref", got_iref, 23);
    check("exh_code", 32'(fail_code), 1);

    set_tab4(600, 100, 100, 100);
    run_sweep(2, 0);
    check("drop_no_det", 32'(setup_done), 0);
    set_tab4(100, 400, 400, 400);
    run_sweep(1, 0);
    check("eq300_no_det", 32'(setup_done), 0);
    set_tab4(100, 401, 401, 401);
    run_sweep(4, 0);
    check("gt300_det", 32'(setup_done), 1);
    check("gt300_bound", got_bound, 1023);

    // Measurement timeout
    resp_mute = 1'b1;
    sweep_id++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!meas_start && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("tmo_meas_start_seen", 32'(meas_start), 1);
    t = 0;
    while (!setup_fail && t < TMO + 100) begin
      @(negedge clk);
      t++;
    end
    check("tmo_latency", t, TMO);
    check("tmo_code", 32'(fail_code), 2);
    check("tmo_busy", 32'(busy), 0);
    check("tmo_iref", 32'(i_ref), START);
    resp_mute = 1'b0;

    // Strobe on the last allowed cycle is accepted
    set_tab4(100, 500, 500, 500);
    run_sweep(TMO - 1, 0);
    check("late_done_ok", 32'(setup_fail), 0);

    // Abort coinciding with the third strobe
    set_tab4(100, 100, 100, 100);
    abort_step = 2;
    resp_lat = 5;
    sweep_id++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("abort_ends", 32'(busy), 0);
    check("abort_time", t, 3 * (SETTLE + 5 + 2) - 1);
    check("abort_iref", 32'(i_ref), START);
    check("abort_done", 32'(setup_done), 0);
    check("abort_fail", 32'(setup_fail), 0);
    check("abort_code", 32'(fail_code), 0);
    repeat (SETTLE + 5) @(negedge clk);
    check("abort_idle_stays", 32'(busy), 0);
    check("abort_pulses", code_log.size(), 3);
    abort_step = -1;
    set_tab4(100, 110, 120, 500);
    run_sweep(5, 0);

    // Reset during step-2 settling
    resp_lat = 5;
    sweep_id++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SETTLE + 5 + 2 + 3) @(negedge clk);
    check("pre_rst_iref", 32'(i_ref), START - STEP);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_iref", 32'(i_ref), START);
    check("mid_rst_bound", 32'(i_ref_bound), 0);
    check("mid_rst_flags", 32'({setup_done, setup_fail, fail_code, meas_start}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized sweeps
    for (int s = 0; s < 12; s++) begin
      int mode = int'($urandom_range(0, 2));
      int v = int'($urandom_range(0, 400));
      for (int k = 0; k < 64; k++) begin
        if (mode == 0) begin
          v = int'($urandom_range(0, 1023));
        end else if (mode == 1) begin
          v = v + int'($urandom_range(0, 640)) - 320;
        end else begin
          v = v + int'($urandom_range(0, 310)) - 100;
        end
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        q_tab[k] = BW'(v);
      end
      run_sweep(int'($urandom_range(1, 8)), int'($urandom_range(1, 30)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
